// File: rtl/polygon_hit_tester_pkg.sv
// Shared widths, form encodings and the sideband record that travels with each
// pixel through the polygon hit test pipeline.
package polygon_hit_tester_pkg;

  localparam int COORD_W     = 10;
  localparam int COLOR_W     = 9;
  localparam int EDGE_W      = 23;
  localparam int DELTA_W     = COORD_W + 1;
  localparam int NUM_EDGES   = 4;
  localparam int HIT_LATENCY = 3;

  localparam logic FORM_SQUARE   = 1'b0;
  localparam logic FORM_TRIANGLE = 1'b1;

  typedef struct packed {
    logic               bubble;
    logic               form;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
  } sideband_t;

  // A cleared slot is an empty (bubble) slot.
  localparam sideband_t SIDEBAND_RESET =
    sideband_t'({1'b1, {(1 + COLOR_W + 2 * COORD_W){1'b0}}});

endpackage

// File: rtl/polygon_hit_tester_edge.sv
// One polygon edge: stage 1 registers the edge/pixel deltas, stage 2 registers
// the full-precision edge function dx*py - dy*px.
module edge_function
  import polygon_hit_tester_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [COORD_W-1:0]       xa,
  input  logic [COORD_W-1:0]       ya,
  input  logic [COORD_W-1:0]       xb,
  input  logic [COORD_W-1:0]       yb,
  input  logic [COORD_W-1:0]       pixel_x,
  input  logic [COORD_W-1:0]       pixel_y,
  output logic signed [EDGE_W-1:0] edge_value
);

  logic signed [DELTA_W-1:0]   dx_reg, dy_reg, px_reg, py_reg;
  logic signed [2*DELTA_W-1:0] prod_a, prod_b;
  logic signed [EDGE_W-1:0]    edge_value_reg;

  function automatic logic signed [DELTA_W-1:0] delta(input logic [COORD_W-1:0] b,
                                                      input logic [COORD_W-1:0] a);
    return $signed({1'b0, b}) - $signed({1'b0, a});
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_reg <= '0;
      dy_reg <= '0;
      px_reg <= '0;
      py_reg <= '0;
    end else if (!stall) begin
      dx_reg <= delta(xb, xa);
      dy_reg <= delta(yb, ya);
      px_reg <= delta(pixel_x, xa);
      py_reg <= delta(pixel_y, ya);
    end
  end

  assign prod_a = dx_reg * py_reg;
  assign prod_b = dy_reg * px_reg;

  // Sign-extend both products by one bit so the difference cannot overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_value_reg <= '0;
    end else if (!stall) begin
      edge_value_reg <= $signed({prod_a[2*DELTA_W-1], prod_a})
                      - $signed({prod_b[2*DELTA_W-1], prod_b});
    end
  end

  assign edge_value = edge_value_reg;

endmodule

// File: rtl/polygon_hit_tester.sv
// Three-stage pixel-in-polygon test for squares and triangles using the signs
// of the per-edge functions; accepts either winding, edges inclusive.
module polygon_hit_tester
  import polygon_hit_tester_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               st3_bubble,
  input  logic [COLOR_W-1:0] st3_color,
  input  logic [COORD_W-1:0] st3_pixel_x,
  input  logic [COORD_W-1:0] st3_pixel_y,
  input  logic [COORD_W-1:0] v1_x,
  input  logic [COORD_W-1:0] v1_y,
  input  logic [COORD_W-1:0] v2_x,
  input  logic [COORD_W-1:0] v2_y,
  input  logic [COORD_W-1:0] v3_x,
  input  logic [COORD_W-1:0] v3_y,
  input  logic [COORD_W-1:0] v4_x,
  input  logic [COORD_W-1:0] v4_y,
  input  logic               form,
  output logic               out_hit,
  output logic [COLOR_W-1:0] out_color,
  output logic [COORD_W-1:0] out_pixel_x,
  output logic [COORD_W-1:0] out_pixel_y,
  output logic               out_bubble
);

  logic [COORD_W-1:0]       vx [NUM_EDGES];
  logic [COORD_W-1:0]       vy [NUM_EDGES];
  logic signed [EDGE_W-1:0] edge_value [NUM_EDGES];
  logic [NUM_EDGES-1:0]     edge_neg, edge_pos, edge_active;
  logic                     all_nonneg, all_nonpos, hit_next;
  sideband_t                sb_in, sb1_reg, sb2_reg;

  logic               out_hit_reg;
  logic [COLOR_W-1:0] out_color_reg;
  logic [COORD_W-1:0] out_pixel_x_reg, out_pixel_y_reg;
  logic               out_bubble_reg;

  assign vx[0] = v1_x;
  assign vy[0] = v1_y;
  assign vx[1] = v2_x;
  assign vy[1] = v2_y;
  assign vx[2] = v3_x;
  assign vy[2] = v3_y;
  assign vx[3] = v4_x;
  assign vy[3] = v4_y;

  generate
    for (genvar gi = 0; gi < NUM_EDGES; gi++) begin : g_edge
      localparam int NEXT = (gi + 1) % NUM_EDGES;
      logic [COORD_W-1:0] xb, yb;

      // Edge V3 closes back to V1 for a triangle; the V4V1 edge is then masked.
      if (gi == 2) begin : g_closing
        assign xb = (form == FORM_TRIANGLE) ? vx[0] : vx[3];
        assign yb = (form == FORM_TRIANGLE) ? vy[0] : vy[3];
      end else begin : g_plain
        assign xb = vx[NEXT];
        assign yb = vy[NEXT];
      end

      edge_function u_edge (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .xa         (vx[gi]),
        .ya         (vy[gi]),
        .xb         (xb),
        .yb         (yb),
        .pixel_x    (st3_pixel_x),
        .pixel_y    (st3_pixel_y),
        .edge_value (edge_value[gi])
      );

      assign edge_neg[gi]    = edge_value[gi][EDGE_W-1];
      assign edge_pos[gi]    = !edge_value[gi][EDGE_W-1] && (edge_value[gi] != '0);
      assign edge_active[gi] = (gi < 3) || (sb2_reg.form == FORM_SQUARE);
    end
  endgenerate

  assign sb_in = '{bubble: st3_bubble, form: form, color: st3_color,
                   pixel_x: st3_pixel_x, pixel_y: st3_pixel_y};

  always_ff @(posedge clk) begin
    if (reset) begin
      sb1_reg <= SIDEBAND_RESET;
      sb2_reg <= SIDEBAND_RESET;
    end else if (!stall) begin
      sb1_reg <= sb_in;
      sb2_reg <= sb1_reg;
    end
  end

  // Both flags set means every active edge is zero: a degenerate polygon.
  always_comb begin
    all_nonneg = &(~edge_neg | ~edge_active);
    all_nonpos = &(~edge_pos | ~edge_active);
    hit_next   = (all_nonneg ^ all_nonpos) && !sb2_reg.bubble;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_hit_reg     <= 1'b0;
      out_color_reg   <= '0;
      out_pixel_x_reg <= '0;
      out_pixel_y_reg <= '0;
      out_bubble_reg  <= 1'b1;
    end else if (!stall) begin
      out_hit_reg     <= hit_next;
      out_color_reg   <= hit_next ? sb2_reg.color : '0;
      out_pixel_x_reg <= sb2_reg.pixel_x;
      out_pixel_y_reg <= sb2_reg.pixel_y;
      out_bubble_reg  <= sb2_reg.bubble;
    end
  end

  assign out_hit     = out_hit_reg;
  assign out_color   = out_color_reg;
  assign out_pixel_x = out_pixel_x_reg;
  assign out_pixel_y = out_pixel_y_reg;
  assign out_bubble  = out_bubble_reg;

endmodule

// File: tb/tb_polygon_hit_tester.sv
// Randomized and directed checks of polygon_hit_tester against a cross-product
// reference model with an explicit latency/stall/reset pipeline.
module tb_polygon_hit_tester;

  logic       clk = 1'b0;
  logic       reset, stall, st3_bubble, form;
  logic [8:0] st3_color;
  logic [9:0] st3_pixel_x, st3_pixel_y;
  logic [9:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, v4_x, v4_y;
  logic       out_hit, out_bubble;
  logic [8:0] out_color;
  logic [9:0] out_pixel_x, out_pixel_y;

  typedef struct packed {
    logic       hit;
    logic [8:0] color;
    logic [9:0] px;
    logic [9:0] py;
    logic       bubble;
  } exp_t;

  localparam exp_t EXP_RESET = '{hit: 1'b0, color: 9'd0, px: 10'd0, py: 10'd0, bubble: 1'b1};

  exp_t pipe [3];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  polygon_hit_tester dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .st3_bubble  (st3_bubble),
    .st3_color   (st3_color),
    .st3_pixel_x (st3_pixel_x),
    .st3_pixel_y (st3_pixel_y),
    .v1_x        (v1_x),
    .v1_y        (v1_y),
    .v2_x        (v2_x),
    .v2_y        (v2_y),
    .v3_x        (v3_x),
    .v3_y        (v3_y),
    .v4_x        (v4_x),
    .v4_y        (v4_y),
    .form        (form),
    .out_hit     (out_hit),
    .out_color   (out_color),
    .out_pixel_x (out_pixel_x),
    .out_pixel_y (out_pixel_y),
    .out_bubble  (out_bubble)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Point-in-polygon by cross products over the polygon's vertex list.
  function automatic exp_t ref_model();
    int   x[4], y[4];
    int   n, j, e;
    bit   any_pos, any_neg;
    exp_t r;
    x = '{int'(v1_x), int'(v2_x), int'(v3_x), int'(v4_x)};
    y = '{int'(v1_y), int'(v2_y), int'(v3_y), int'(v4_y)};
    n = form ? 3 : 4;
    any_pos = 0;
    any_neg = 0;
    for (int i = 0; i < n; i++) begin
      j = (i + 1) % n;
      e = (x[j] - x[i]) * (int'(st3_pixel_y) - y[i]) - (y[j] - y[i]) * (int'(st3_pixel_x) - x[i]);
      if (e > 0) any_pos = 1;
      if (e < 0) any_neg = 1;
    end
    r.hit    = !st3_bubble && (any_pos || any_neg) && !(any_pos && any_neg);
    r.color  = r.hit ? st3_color : 9'd0;
    r.px     = st3_pixel_x;
    r.py     = st3_pixel_y;
    r.bubble = st3_bubble;
    return r;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (reset) pipe = '{EXP_RESET, EXP_RESET, EXP_RESET};
    else if (!stall) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = ref_model();
    end
    #1;
    e = pipe[2];
    check("out_hit", 32'(out_hit), 32'(e.hit));
    check("out_color", 32'(out_color), 32'(e.color));
    check("out_pixel_x", 32'(out_pixel_x), 32'(e.px));
    check("out_pixel_y", 32'(out_pixel_y), 32'(e.py));
    check("out_bubble", 32'(out_bubble), 32'(e.bubble));
    $display("t=%0t rst=%0b stall=%0b -> hit=%0b color=%h px=%0d py=%0d bubble=%0b",
             $time, reset, stall, out_hit, out_color, out_pixel_x, out_pixel_y, out_bubble);
  endtask

  task automatic set_verts(input bit f, input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int dx, input int dy);
    form = f;
    v1_x = 10'(ax); v1_y = 10'(ay); v2_x = 10'(bx); v2_y = 10'(by);
    v3_x = 10'(cx); v3_y = 10'(cy); v4_x = 10'(dx); v4_y = 10'(dy);
  endtask

  task automatic set_pix(input int px, input int py, input int color, input bit bubble);
    st3_pixel_x = 10'(px);
    st3_pixel_y = 10'(py);
    st3_color   = 9'(color);
    st3_bubble  = bubble;
  endtask

  // One slot, then two idle bubbles; the slot's result is then on the outputs.
  task automatic run_single(input string tag, input int px, input int py, input int color,
                            input bit exp_hit);
    set_pix(px, py, color, 1'b0);
    step();
    set_pix(0, 0, 0, 1'b1);
    step();
    step();
    check({tag, "_hit"}, 32'(out_hit), 32'(exp_hit));
    check({tag, "_color"}, 32'(out_color), exp_hit ? 32'(color) : 32'd0);
    check({tag, "_px"}, 32'(out_pixel_x), 32'(px));
  endtask

  initial begin
    int idx, lim, mode;
    reset = 1'b1;
    stall = 1'b0;
    set_verts(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_pix(0, 0, 0, 1'b1);
    step();
    check("reset_bubble", 32'(out_bubble), 32'd1);
    stall = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;

    // Square and its inclusive right edge.
    set_verts(0, 100, 100, 200, 100, 200, 200, 100, 200);
    run_single("sq_center", 150, 150, 'h1A5, 1'b1);
    run_single("sq_outside", 201, 150, 'h0F0, 1'b0);
    run_single("sq_edge", 200, 150, 'h033, 1'b1);
    run_single("sq_corner", 100, 100, 'h111, 1'b1);

    // Triangle in both windings; v4 must be ignored.
    set_verts(1, 10, 10, 60, 10, 10, 60, 500, 500);
    run_single("tri_in", 20, 20, 'h07F, 1'b1);
    run_single("tri_out", 50, 50, 'h07F, 1'b0);
    set_verts(1, 10, 10, 10, 60, 60, 10, 500, 500);
    run_single("tri_rev_in", 20, 20, 'h155, 1'b1);
    run_single("tri_rev_out", 50, 50, 'h155, 1'b0);

    // Stream of 8 with alternating bubbles; stall on cycles 3-4 with junk inputs.
    set_verts(0, 100, 100, 200, 100, 200, 200, 100, 200);
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      stall = (cyc == 3 || cyc == 4);
      if (stall || idx >= 8) set_pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                                     int'($urandom_range(0, 511)), stall ? 1'b0 : 1'b1);
      else set_pix(140 + 10 * idx, 150, 'h100 + idx, idx[0]);
      step();
      if (!stall && idx < 8) idx++;
    end
    stall = 1'b0;

    // Reset with three slots in flight.
    for (int i = 0; i < 3; i++) begin
      set_pix(150 + i, 150, 'h1FF, 1'b0);
      step();
    end
    reset = 1'b1;
    stall = 1'b1;
    step();
    check("rst_inflight_bubble", 32'(out_bubble), 32'd1);
    check("rst_inflight_hit", 32'(out_hit), 32'd0);
    check("rst_inflight_color", 32'(out_color), 32'd0);
    check("rst_inflight_px", 32'(out_pixel_x), 32'd0);
    reset = 1'b0;
    stall = 1'b0;

    set_verts(0, 5, 5, 5, 5, 5, 5, 5, 5);
    run_single("degenerate", 5, 5, 'h0AA, 1'b0);

    // Randomized traffic with stalls, bubbles and occasional resets.
    for (int n = 0; n < 600; n++) begin
      mode = int'($urandom_range(0, 2));
      lim  = (mode == 0) ? 15 : 1023;
      if (mode == 2) begin
        int x0, y0, w, h;
        x0 = int'($urandom_range(0, 800));
        y0 = int'($urandom_range(0, 800));
        w  = int'($urandom_range(0, 200));
        h  = int'($urandom_range(0, 200));
        set_verts(1'($urandom_range(0, 1)), x0, y0, x0 + w, y0, x0 + w, y0 + h, x0, y0 + h);
        set_pix(x0 + int'($urandom_range(0, 220)) - 10, y0 + int'($urandom_range(0, 220)) - 10,
                int'($urandom_range(0, 511)), ($urandom_range(0, 4) == 0));
      end else begin
        set_verts(1'($urandom_range(0, 1)),
                  int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                  int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                  int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                  int'($urandom_range(0, lim)), int'($urandom_range(0, lim)));
        set_pix(int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                int'($urandom_range(0, 511)), ($urandom_range(0, 4) == 0));
      end
      stall = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/polygon_hit_tester.md
POLYGON_HIT_TESTER -- requirements
Module: polygon_hit_tester

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: stall  input  1  when high, all pipeline registers hold their value.
REQ-004 SHALL: st3_bubble  input  1  incoming slot carries no valid pixel.
REQ-005 SHALL: st3_color  input  9  sprite color for the current pixel.
REQ-006 SHALL: st3_pixel_x / st3_pixel_y  input  10 each  screen coordinate under test.
REQ-007 SHALL: vN_x / vN_y (N=1..4)  input  10 each  unsigned polygon vertices from the vertex calculator, same slot as the pixel.
REQ-008 SHALL: form  input  1  0 = square (v1..v4), 1 = triangle (v1..v3; v4 ignored).
REQ-009 SHALL: out_hit  output  1  pixel lies inside or on the polygon.
REQ-010 SHALL: out_color  output  9  st3_color if hit, else 9'd0.
REQ-011 SHALL: out_pixel_x / out_pixel_y  output  10 each  pixel coordinate delayed to match out_hit.
REQ-012 SHALL: out_bubble  output  1  delayed st3_bubble.

Function
REQ-013 SHALL: fixed latency of 3 unstalled cycles from input sample to outputs; one new slot accepted per unstalled cycle.
REQ-014 SHALL: stage 1 register signed 11-bit deltas per edge Ei=(Va->Vb): dx=xb-xa, dy=yb-ya, px=pixel_x-xa, py=pixel_y-ya.
REQ-015 SHALL: stage 2 register signed 23-bit edge value e = dx*py - dy*px (22-bit products, full precision, no truncation).
REQ-016 SHALL: edges are V1V2, V2V3, V3V4, V4V1 for square; V1V2, V2V3, V3V1 for triangle (form selects the closing edge at stage 1).
REQ-017 SHALL: stage 3 set hit=1 when all active edge values are >=0 or all are <=0 (either winding; edges and vertices inclusive).
REQ-018 SHALL: all active edge values equal to zero (degenerate polygon) yield hit=0.
REQ-019 SHALL: bubble slot forces out_hit=0, out_color=0, out_bubble=1; pixel coordinates still propagate.
REQ-020 SHALL: form, color, pixel and bubble travel in sideband registers aligned with the arithmetic stages.
REQ-021 SHALL: stall high freezes every stage including outputs; input sampled during stall is ignored; release resumes without loss or duplication.

Reset
REQ-022 SHALL: reset high on a clock edge clear all stage registers; outputs read out_hit=0, out_color=0, out_pixel_x=0, out_pixel_y=0, out_bubble=1.
REQ-023 SHALL: reset take precedence over stall; reset mid-operation discards all in-flight slots (first valid output 3 cycles after reset release).

Structure
REQ-024 SHALL: shared package hold COORD_W=10, COLOR_W=9, EDGE_W=23, FORM_SQUARE=1'b0, FORM_TRIANGLE=1'b1, HIT_LATENCY=3.
REQ-025 SHALL: one sub-module edge_function (delta and product registers for one edge, with stall and reset), instantiated four times.

Verification
REQ-026 SHALL: square v=(100,100),(200,100),(200,200),(100,200), pixel (150,150), color 9'h1A5 -> after 3 cycles out_hit=1, out_color=9'h1A5.
REQ-027 SHALL: same square, pixel (201,150) -> out_hit=0, out_color=0; pixel (200,150) -> out_hit=1 (edge inclusive).
REQ-028 SHALL: triangle form=1, v=(10,10),(60,10),(10,60), v4=(500,500), pixels (20,20) and (50,50) -> hit=1 then hit=0; same vertices reversed winding give identical results.
REQ-029 SHALL: back-to-back stream of 8 pixels alternating bubble, with stall high for cycles 3-4 -> outputs in order, shifted 2 cycles, bubbles reported with hit=0.
REQ-030 SHALL: reset asserted while 3 slots in flight -> next cycle out_bubble=1, out_hit=0, other outputs 0; degenerate square with all vertices (5,5), pixel (5,5) -> hit=0.
